// File: rtl/btb_update_queue.sv
// btb_update_queue
//   Training-side front end for the branch target buffer. Resolved-branch
//   reports are filtered to taken branches the BTB got wrong and buffered in
//   a small FIFO. Reports for a PC that is already queued overwrite that
//   entry's target instead of taking a new slot.
//
//   The BTB has one SRAM port. A queued update is issued on any cycle where
//   fetch is idle. If the head entry has waited STARVE_MAX cycles, fetch is
//   stalled for one cycle and the update is issued instead.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   res_valid/pc/target/taken      resolved-branch report from the backend
//   res_btb_hit/res_pred_target    what the BTB predicted for that PC
//   fetch_req, fetch_pc_in         lookup request from the front end
//   btb_fetch, btb_fetch_pc        gated lookup strobe and PC to the BTB
//   btb_update, btb_pc, btb_target write strobe and head entry to the BTB
//   fetch_stall                    front end must hold its PC and retry
//   q_count                        queue occupancy
//   drop_cnt                       saturating count of discarded reports
module btb_update_queue #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8,
    parameter int DROP_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       res_valid,
    input  logic [31:0]                res_pc,
    input  logic [31:0]                res_target,
    input  logic                       res_taken,
    input  logic                       res_btb_hit,
    input  logic [31:0]                res_pred_target,
    input  logic                       fetch_req,
    input  logic [31:0]                fetch_pc_in,
    output logic                       btb_fetch,
    output logic [31:0]                btb_fetch_pc,
    output logic                       btb_update,
    output logic [31:0]                btb_pc,
    output logic [31:0]                btb_target,
    output logic                       fetch_stall,
    output logic [$clog2(DEPTH):0]     q_count,
    output logic [DROP_W-1:0]          drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SW    = $clog2(STARVE_MAX + 1);

    logic [29:0]      pc_mem  [DEPTH];
    logic [29:0]      tgt_mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [SW-1:0]    starve_cnt;
    logic [DROP_W-1:0] drops;

    logic             empty;
    logic             full;
    logic             force_upd;
    logic             deq;
    logic             need;
    logic [DEPTH-1:0] match;
    logic [PTR_W-1:0] match_idx;
    logic             coalesce;
    logic             enq;
    logic             drop_evt;

    // Low address bits are never stored; entries are word-aligned.
    logic unused_low_bits;
    assign unused_low_bits = ^{res_pc[1:0], res_target[1:0]};

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // Arbitration is gated by rst so nothing issues to the BTB while the
    // queue is being discarded.
    assign force_upd   = ~rst & ~empty & (starve_cnt == SW'(STARVE_MAX));
    assign btb_update  = ~rst & ~empty & (~fetch_req | force_upd);
    assign fetch_stall = fetch_req & force_upd;
    assign btb_fetch   = fetch_req & ~force_upd;
    assign btb_fetch_pc = fetch_pc_in;
    assign deq         = btb_update;

    assign btb_pc     = {pc_mem[head], 2'b00};
    assign btb_target = {tgt_mem[head], 2'b00};
    assign q_count    = count;
    assign drop_cnt   = drops;

    assign need = res_valid & res_taken &
                  (~res_btb_hit | (res_pred_target != res_target));

    // A head entry that leaves this cycle cannot absorb the report; the
    // report then becomes a fresh entry so the newer target is not lost.
    always_comb begin
        match     = '0;
        match_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (pc_mem[i] == res_pc[31:2]) &&
                !(deq && (head == PTR_W'(i)))) begin
                match[i]  = 1'b1;
                match_idx = PTR_W'(i);
            end
        end
    end

    assign coalesce = need & (|match);
    assign enq      = need & ~coalesce & (~full | deq);
    assign drop_evt = need & ~coalesce & full & ~deq;

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            valid      <= '0;
            starve_cnt <= '0;
            drops      <= '0;
        end else begin
            // On full-with-dequeue tail equals head; the later set wins.
            if (deq) begin
                valid[head] <= 1'b0;
                head        <= head + PTR_W'(1);
            end
            if (enq) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PTR_W'(1);
            end

            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (deq || empty) begin
                starve_cnt <= '0;
            end else if (starve_cnt != SW'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end

            if (drop_evt && (drops != '1)) begin
                drops <= drops + DROP_W'(1);
            end
        end
    end

    // Payload storage needs no reset; occupancy is tracked by valid/count.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[tail]  <= res_pc[31:2];
            tgt_mem[tail] <= res_target[31:2];
        end
        if (coalesce) begin
            tgt_mem[match_idx] <= res_target[31:2];
        end
    end

endmodule

// File: tb/tb_btb_update_queue.sv
// tb_btb_update_queue
//   Directed bench for btb_update_queue (DEPTH=4, STARVE_MAX=8, DROP_W=16).
//   Inputs change 1 time unit after the rising edge; outputs are checked one
//   unit later, well away from the next edge.
module tb_btb_update_queue;

    logic        clk;
    logic        rst;
    logic        res_valid;
    logic [31:0] res_pc;
    logic [31:0] res_target;
    logic        res_taken;
    logic        res_btb_hit;
    logic [31:0] res_pred_target;
    logic        fetch_req;
    logic [31:0] fetch_pc_in;
    logic        btb_fetch;
    logic [31:0] btb_fetch_pc;
    logic        btb_update;
    logic [31:0] btb_pc;
    logic [31:0] btb_target;
    logic        fetch_stall;
    logic [2:0]  q_count;
    logic [15:0] drop_cnt;

    int n_chk;
    int n_bad;

    btb_update_queue #(
        .DEPTH(4),
        .STARVE_MAX(8),
        .DROP_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .res_valid(res_valid),
        .res_pc(res_pc),
        .res_target(res_target),
        .res_taken(res_taken),
        .res_btb_hit(res_btb_hit),
        .res_pred_target(res_pred_target),
        .fetch_req(fetch_req),
        .fetch_pc_in(fetch_pc_in),
        .btb_fetch(btb_fetch),
        .btb_fetch_pc(btb_fetch_pc),
        .btb_update(btb_update),
        .btb_pc(btb_pc),
        .btb_target(btb_target),
        .fetch_stall(fetch_stall),
        .q_count(q_count),
        .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic report(input logic [31:0] pc, input logic [31:0] tgt,
                          input logic tk, input logic hit, input logic [31:0] pred);
        res_valid       = 1'b1;
        res_pc          = pc;
        res_target      = tgt;
        res_taken       = tk;
        res_btb_hit     = hit;
        res_pred_target = pred;
    endtask

    task automatic quiet();
        res_valid = 1'b0;
    endtask

    logic [31:0] wpc;

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst         = 1'b1;
        fetch_req   = 1'b1;
        fetch_pc_in = 32'h0000_4000;
        report(32'h0000_0900, 32'h0000_0990, 1'b1, 1'b0, 32'h0);

        // reset held two cycles with a live report
        tick(); settle();
        chk("rst_update", {31'b0, btb_update}, 32'd0);
        chk("rst_stall", {31'b0, fetch_stall}, 32'd0);
        chk("rst_fetch", {31'b0, btb_fetch}, 32'd1);
        chk("rst_count", {29'b0, q_count}, 32'd0);
        chk("rst_drop", {16'b0, drop_cnt}, 32'd0);
        tick();
        rst = 1'b0;
        quiet();
        fetch_req = 1'b0;
        settle();
        chk("rst_count2", {29'b0, q_count}, 32'd0);
        chk("rst_fetch_off", {31'b0, btb_fetch}, 32'd0);
        chk("fetch_pc_pass", btb_fetch_pc, 32'h0000_4000);

        // idle drain
        report(32'h1000_0040, 32'h1000_0100, 1'b1, 1'b0, 32'h0);
        settle();
        chk("drain_noupd_empty", {31'b0, btb_update}, 32'd0);
        tick(); quiet(); settle();
        chk("drain_count", {29'b0, q_count}, 32'd1);
        chk("drain_update", {31'b0, btb_update}, 32'd1);
        chk("drain_pc", btb_pc, 32'h1000_0040);
        chk("drain_tgt", btb_target, 32'h1000_0100);
        tick(); settle();
        chk("drain_count0", {29'b0, q_count}, 32'd0);
        chk("drain_update0", {31'b0, btb_update}, 32'd0);

        // filter: correct prediction and not-taken are ignored
        fetch_req = 1'b1;
        report(32'h0000_0500, 32'h0000_0600, 1'b1, 1'b1, 32'h0000_0600);
        tick(); quiet(); settle();
        chk("filter_correct", {29'b0, q_count}, 32'd0);
        report(32'h0000_0504, 32'h0000_0700, 1'b0, 1'b0, 32'h0);
        tick(); quiet(); settle();
        chk("filter_nottaken", {29'b0, q_count}, 32'd0);

        // coalesce: two mispredicts for the same PC
        report(32'h0000_0200, 32'h0000_0300, 1'b1, 1'b0, 32'h0);
        tick();
        report(32'h0000_0200, 32'h0000_0400, 1'b1, 1'b1, 32'h0000_0300);
        tick(); quiet(); settle();
        chk("coal_count", {29'b0, q_count}, 32'd1);
        fetch_req = 1'b0;
        settle();
        chk("coal_update", {31'b0, btb_update}, 32'd1);
        chk("coal_pc", btb_pc, 32'h0000_0200);
        chk("coal_tgt", btb_target, 32'h0000_0400);
        tick(); settle();
        chk("coal_count0", {29'b0, q_count}, 32'd0);

        // starvation: forced update exactly when the head has waited 8 cycles
        fetch_req = 1'b1;
        report(32'h0000_0800, 32'h0000_0900, 1'b1, 1'b0, 32'h0);
        tick(); quiet(); settle();
        for (int k = 0; k <= 8; k++) begin
            chk($sformatf("starve_stall_%0d", k), {31'b0, fetch_stall}, (k == 8) ? 32'd1 : 32'd0);
            chk($sformatf("starve_upd_%0d", k), {31'b0, btb_update}, (k == 8) ? 32'd1 : 32'd0);
            chk($sformatf("starve_fetch_%0d", k), {31'b0, btb_fetch}, (k == 8) ? 32'd0 : 32'd1);
            tick(); settle();
        end
        chk("starve_empty", {29'b0, q_count}, 32'd0);
        chk("starve_stall_off", {31'b0, fetch_stall}, 32'd0);
        chk("starve_fetch_on", {31'b0, btb_fetch}, 32'd1);

        // full and drop
        for (int i = 0; i < 4; i++) begin
            wpc = 32'h0000_0A00 + 32'(i * 4);
            report(wpc, wpc + 32'h1000, 1'b1, 1'b0, 32'h0);
            tick();
        end
        settle();
        chk("full_count", {29'b0, q_count}, 32'd4);
        report(32'h0000_0A10, 32'h0000_1A10, 1'b1, 1'b0, 32'h0);
        tick(); quiet(); settle();
        chk("drop_cnt1", {16'b0, drop_cnt}, 32'd1);
        chk("drop_count", {29'b0, q_count}, 32'd4);
        chk("drop_noupd", {31'b0, btb_update}, 32'd0);
        tick(); tick(); tick(); settle();
        chk("pre_force_noupd", {31'b0, btb_update}, 32'd0);
        tick(); settle();
        chk("force_stall", {31'b0, fetch_stall}, 32'd1);
        chk("force_update", {31'b0, btb_update}, 32'd1);
        chk("force_pc", btb_pc, 32'h0000_0A00);
        report(32'h0000_0A14, 32'h0000_1A14, 1'b1, 1'b0, 32'h0);
        tick(); quiet(); settle();
        chk("fullenq_count", {29'b0, q_count}, 32'd4);
        chk("fullenq_drop", {16'b0, drop_cnt}, 32'd1);
        fetch_req = 1'b0;
        settle();
        chk("order_0", btb_pc, 32'h0000_0A04);
        tick(); settle();
        chk("order_1", btb_pc, 32'h0000_0A08);
        tick(); settle();
        chk("order_2", btb_pc, 32'h0000_0A0C);
        tick(); settle();
        chk("order_3", btb_pc, 32'h0000_0A14);
        chk("order_3_tgt", btb_target, 32'h0000_1A14);
        tick(); settle();
        chk("order_empty", {29'b0, q_count}, 32'd0);

        // wrap: enqueue and dequeue in the same cycle, 10 times
        report(32'h0000_2000, 32'h0000_3000, 1'b1, 1'b0, 32'h0);
        tick();
        for (int i = 1; i <= 10; i++) begin
            if (i < 10) begin
                wpc = 32'h0000_2000 + 32'(i * 16);
                report(wpc, wpc + 32'h1000, 1'b1, 1'b0, 32'h0);
            end else begin
                quiet();
            end
            settle();
            wpc = 32'h0000_2000 + 32'((i - 1) * 16);
            chk($sformatf("wrap_upd_%0d", i), {31'b0, btb_update}, 32'd1);
            chk($sformatf("wrap_pc_%0d", i), btb_pc, wpc);
            chk($sformatf("wrap_tgt_%0d", i), btb_target, wpc + 32'h1000);
            chk($sformatf("wrap_cnt_%0d", i), {29'b0, q_count}, 32'd1);
            tick();
        end
        settle();
        chk("wrap_empty", {29'b0, q_count}, 32'd0);

        // mid-operation reset with three entries queued
        fetch_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wpc = 32'h0000_0C00 + 32'(i * 4);
            report(wpc, wpc + 32'h100, 1'b1, 1'b0, 32'h0);
            tick();
        end
        quiet(); settle();
        chk("mid_count3", {29'b0, q_count}, 32'd3);
        rst = 1'b1;
        fetch_req = 1'b0;
        report(32'h0000_0C10, 32'h0000_0D10, 1'b1, 1'b0, 32'h0);
        settle();
        chk("mid_rst_noupd", {31'b0, btb_update}, 32'd0);
        chk("mid_rst_nostall", {31'b0, fetch_stall}, 32'd0);
        tick();
        rst = 1'b0;
        quiet();
        settle();
        chk("mid_count0", {29'b0, q_count}, 32'd0);
        chk("mid_noupd", {31'b0, btb_update}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/btb_update_queue.md
Name: btb_update_queue

Overview:
Training-side front end for the branch target buffer. It takes resolved-branch reports from the backend, filters them to taken branches the BTB got wrong, and buffers them in a small queue. It owns arbitration of the BTB's single SRAM port: queued updates go out on cycles when fetch is idle, and fetch is stalled for one cycle if an update has waited too long. It drives the BTB's pc/target/update inputs and the gated fetch strobe.

Parameters:
DEPTH, 4, queue entries (power of 2, >=2)
STARVE_MAX, 8, cycles a head entry may wait before fetch is stalled (>=1)
DROP_W, 16, width of saturating drop counter

Ports:
Clock and reset are synchronous; rst is active-high.
clk  input  1  clock
rst  input  1  synchronous active-high reset
res_valid  input  1  backend resolved a control-flow instruction this cycle
res_pc  input  32  PC of resolved branch
res_target  input  32  actual target
res_taken  input  1  branch actually taken
res_btb_hit  input  1  fetch had predict_valid for this PC
res_pred_target  input  32  predicted target (meaningful when res_btb_hit)
fetch_req  input  1  front end wants a BTB lookup this cycle
fetch_pc_in  input  32  lookup PC
btb_fetch  output  1  to BTB fetch
btb_fetch_pc  output  32  to BTB fetch_pc (= fetch_pc_in)
btb_update  output  1  to BTB update
btb_pc  output  32  to BTB pc (head entry PC)
btb_target  output  32  to BTB target (head entry target)
fetch_stall  output  1  front end must hold fetch_pc and retry next cycle
q_count  output  $clog2(DEPTH)+1  occupancy
drop_cnt  output  DROP_W  saturating count of dropped trainings

Behaviour:
- Reset: queue empty, q_count=0, starvation counter=0, drop_cnt=0. Outputs btb_update=0, fetch_stall=0, btb_fetch=fetch_req. btb_pc/btb_target show the stale head and are don't-care while btb_update=0. Reset mid-operation discards all entries; no update issues in the reset cycle.
- Train condition: need = res_valid & res_taken & (~res_btb_hit | res_pred_target != res_target). Not-taken and correctly predicted branches are ignored.
- Entry: {pc[31:2], target[31:2]}. btb_pc[1:0] and btb_target[1:0] are driven 0.
- Arbitration is combinational from registered state:
  - force = ~empty & (starve_cnt == STARVE_MAX)
  - btb_update = ~empty & (~fetch_req | force)
  - fetch_stall = fetch_req & force
  - btb_fetch = fetch_req & ~force
  - btb_update and btb_fetch are never both 1.
- Dequeue: the head pops in any cycle btb_update=1. Update-to-BTB latency is zero extra cycles. Minimum enqueue-to-update latency is 1 cycle, because an entry written at edge N is visible as head in cycle N+1.
- Starvation counter:
  - cleared on dequeue and whenever the queue is empty;
  - otherwise increments, saturating at STARVE_MAX.
  - fetch_stall lasts exactly one cycle per forced update.
- Coalescing: if need and some valid entry has a matching pc[31:2], that entry's target is overwritten; no new entry and no drop. Exception: if the match is the head and the head is dequeuing this cycle, the report is treated as a normal enqueue. At most one entry per PC is ever present.
- Enqueue: if need, no coalesce, and (not full or dequeue this cycle), write at tail. Full with simultaneous dequeue is accepted, and count stays DEPTH.
- Drop: need, no coalesce, full, and no dequeue -> report discarded; drop_cnt += 1, saturating at all-ones.
- Enqueue and dequeue in the same cycle: count unchanged, pointers both advance and wrap modulo DEPTH.
- No flush input: training survives pipeline flushes.

Test Plan:
- Reset: rst held 2 cycles with res_valid=1 -> q_count=0, btb_update=0, drop_cnt=0, btb_fetch follows fetch_req.
- Idle drain: fetch_req=0; enqueue pc=0x1000_0040, target=0x1000_0100, taken, btb_hit=0 -> next cycle btb_update=1, btb_pc=0x1000_0040, btb_target=0x1000_0100, q_count returns to 0.
- Filter and coalesce:
  - taken with btb_hit=1 and pred_target==target -> no enqueue;
  - not-taken -> no enqueue;
  - two mispredicts for pc 0x200 (targets 0x300 then 0x400) with fetch_req=1 -> q_count=1, eventual btb_target=0x400.
- Starvation: fetch_req held 1 with one queued entry -> fetch_stall=1 and btb_update=1 in exactly the cycle starve_cnt hits 8, btb_fetch=0 that cycle only, then the queue is empty.
- Full/drop: fetch_req=1, four distinct PCs enqueued, then a fifth before any forced dequeue -> drop_cnt=1, q_count=4. A fifth arriving in a forced-dequeue cycle -> accepted, q_count=4, drop_cnt unchanged.
- Wrap and mid-op reset: 10 enqueue/dequeue pairs -> updates issue in FIFO order across pointer wrap. rst asserted with 3 entries queued -> next cycle q_count=0, no btb_update.
